// File: rtl/nonrestoring_divider.sv
// Iterative radix-2 non-restoring divider: one quotient bit per clock, WIDTH+1 cycle latency.
// Define DIVIDER_SIGNED_EN for two's-complement operands; otherwise operands are unsigned.
module nonrestoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   p;      // signed partial remainder
  logic [WIDTH-1:0] a;      // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs;    // divisor magnitude
  logic [WIDTH-1:0] x_reg;  // original dividend, returned as remainder on divide by zero

  logic [WIDTH-1:0] x_abs, y_abs;
  logic [WIDTH:0]   p_sh, p_nxt, p_fix;
  logic [WIDTH-1:0] a_nxt, q_res, r_res;
  logic             ovf_res;

`ifdef DIVIDER_SIGNED_EN
  logic sign_x, sign_y;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
`ifdef DIVIDER_SIGNED_EN
    x_abs = X[WIDTH-1] ? -X : X;
    y_abs = Y[WIDTH-1] ? -Y : Y;
`else
    x_abs = X;
    y_abs = Y;
`endif

    // One non-restoring step; W+1-bit wrap is harmless since the result lies in [-dvs, dvs).
    p_sh  = {p[WIDTH-1:0], a[WIDTH-1]};
    p_nxt = p[WIDTH] ? (p_sh + {1'b0, dvs}) : (p_sh - {1'b0, dvs});
    a_nxt = {a[WIDTH-2:0], ~p_nxt[WIDTH]};

    p_fix = p[WIDTH] ? (p + {1'b0, dvs}) : p;

`ifdef DIVIDER_SIGNED_EN
    q_res   = (sign_x ^ sign_y) ? -a : a;
    r_res   = sign_x ? -p_fix[WIDTH-1:0] : p_fix[WIDTH-1:0];
    ovf_res = sign_x && sign_y && (x_reg == MOST_NEG) && (dvs == WIDTH'(1));
`else
    q_res   = a;
    r_res   = p_fix[WIDTH-1:0];
    ovf_res = 1'b0;
`endif

    if (dvs == '0) begin
      q_res   = '1;
      r_res   = x_reg;
      ovf_res = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      p     <= '0;
      a     <= '0;
      dvs   <= '0;
      x_reg <= '0;
      Q     <= '0;
      R     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dbz   <= 1'b0;
      ovf   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      sign_x <= 1'b0;
      sign_y <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_reg <= X;
            a     <= x_abs;
            dvs   <= y_abs;
            p     <= '0;
            cnt   <= CW'(WIDTH - 1);
            busy  <= 1'b1;
            state <= ITER;
`ifdef DIVIDER_SIGNED_EN
            sign_x <= X[WIDTH-1];
            sign_y <= Y[WIDTH-1];
`endif
          end
        end
        ITER: begin
          p <= p_nxt;
          a <= a_nxt;
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - CW'(1);
        end
        FIX: begin
          Q     <= q_res;
          R     <= r_res;
          dbz   <= (dvs == '0);
          ovf   <= ovf_res;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Directed bench for nonrestoring_divider (WIDTH=8); vectors follow the DIVIDER_SIGNED_EN build.
module tb_nonrestoring_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] X = '0;
  logic [7:0] Y = '0;
  logic [7:0] Q, R;
  logic       busy, done, dbz, ovf;

  int vectors = 0;
  int miscompares = 0;
  bit glitch = 1'b0;

  nonrestoring_divider #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .X(X), .Y(Y),
    .Q(Q), .R(R), .busy(busy), .done(done), .dbz(dbz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation (optionally in the current done cycle) and check its result and timing.
  task automatic run(input string tag, input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] eq, input logic [7:0] er,
                     input logic edbz, input logic eovf, input bit b2b);
    int lat;
    int bn;
    if (!b2b) @(negedge clk);
    start = 1'b1; X = x; Y = y;
    @(negedge clk);
    start = 1'b0; X = 8'($urandom); Y = 8'($urandom);
    lat = 0;
    bn  = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) bn++;
      if (!done && glitch && (lat == 2 || lat == 4)) begin
        start = 1'b1; X = 8'h55; Y = 8'h02;
      end else begin
        start = 1'b0;
      end
    end
    check({tag, ".latency"}, lat, 9);
    check({tag, ".busy_cycles"}, bn, 9);
    check({tag, ".busy_at_done"}, {31'd0, busy}, 0);
    check({tag, ".q"}, {24'd0, Q}, {24'd0, eq});
    check({tag, ".r"}, {24'd0, R}, {24'd0, er});
    check({tag, ".dbz"}, {31'd0, dbz}, {31'd0, edbz});
    check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eovf});
  endtask

  initial begin
    int done_cnt;

    repeat (2) @(negedge clk);
    check("reset.outputs", {16'd0, Q, R} | {28'd0, busy, done, dbz, ovf}, 0);
    rst_n = 1'b1;

    run("div_100_7", 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("done_single_pulse", {31'd0, done}, 0);
    repeat (3) @(negedge clk);
    check("hold.q", {24'd0, Q}, 32'h0E);
    check("hold.r", {24'd0, R}, 32'h02);

`ifdef DIVIDER_SIGNED_EN
    run("div_m100_7",  8'h9C, 8'd7,  8'hF2, 8'hFE, 1'b0, 1'b0, 1'b0);
    run("div_100_m7",  8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, 1'b0);
    run("div_m100_m7", 8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0, 1'b0);
    run("ovf",         8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0);
`else
    run("div_200_7",   8'd200, 8'd7, 8'h1C, 8'h04, 1'b0, 1'b0, 1'b0);
    run("div_255_1",   8'd255, 8'd1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
    run("div_128_255", 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 1'b0, 1'b0);
`endif
    run("dbz", 8'd45, 8'd0, 8'hFF, 8'h2D, 1'b1, 1'b0, 1'b0);

    // Start pulses during busy are ignored; start in the done cycle is accepted.
    glitch = 1'b1;
    run("ignore_start", 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0, 1'b0);
    glitch = 1'b0;
    run("back_to_back", 8'd59, 8'd6, 8'h09, 8'h05, 1'b0, 1'b0, 1'b1);

    // Reset mid-operation discards the result immediately.
    @(negedge clk);
    start = 1'b1; X = 8'd50; Y = 8'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset.outputs", {16'd0, Q, R} | {28'd0, busy, done, dbz, ovf}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midreset.no_done", done_cnt, 0);
    run("after_reset", 8'd9, 8'd3, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
